if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the single-issue MIPS core: owns the PC, drives the
//  word address into the instruction memory and captures the returned word into the
//  IF/ID pipeline register for the decoder. Supports stall, flush, branch/jump
//  redirect and a halt state when fetch leaves the program image.
// PARAMETERS
//  RESET_PC  32'h0000_0000  byte address of first instruction
//  IM_DEPTH  64             instruction-memory depth in words; fetch beyond it halts
// PORTS
//  clk          in   1   core clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  stall        in   1   hold PC and IF/ID (load-use hazard from ID)
//  flush        in   1   replace IF/ID contents with a bubble
//  redirect     in   1   taken branch/jump; load PC from redirect_pc
//  redirect_pc  in   32  target byte address
//  halt_req     in   1   enter HALT at next edge
//  im_data      in   32  instruction word returned by instruction memory (combinational)
//  im_addr      out  32  word address to instruction memory = {2'b00, pc[31:2]}
//  if_pc        out  32  byte PC of instruction held in IF/ID
//  if_pc4       out  32  if_pc + 4
//  if_instr     out  32  captured instruction; 32'h0000_0000 (NOP) when bubble
//  if_valid     out  1   IF/ID holds a real instruction
//  halted       out  1   FSM in HALT
// BEHAVIOUR
//  Reset (async, immediate): pc=RESET_PC, state=BOOT, if_pc=if_pc4=if_instr=0,
//   if_valid=0, halted=0; im_addr follows pc combinationally at all times.
//  FSM: BOOT -> RUN unconditionally at first edge after rst falls (memory image
//   loads on reset release; nothing is captured in BOOT, pc held).
//   RUN -> HALT on edge where halt_req=1, or where pc[31:2] >= IM_DEPTH.
//   HALT is sticky until rst; halted=1 from the edge entering HALT.
//  RUN, per rising edge, priority order:
//   PC:    redirect -> pc<=redirect_pc (overrides stall); else stall -> hold;
//          else pc<=pc+4 (32-bit, wraps 0xFFFF_FFFC -> 0).
//   IF/ID: flush -> bubble (overrides stall); else stall -> hold;
//          else capture {pc, pc+4, im_data}, if_valid=1.
//   redirect without flush still captures current word; ID asserts flush with it.
//  Out-of-range fetch (pc[31:2] >= IM_DEPTH): word not captured, IF/ID <= bubble,
//   pc held, state -> HALT same edge.
//  halt_req together with redirect: HALT wins, pc still loads redirect_pc.
//  HALT: pc held; IF/ID <= bubble each edge unless stall=1 (then hold, so older
//   instruction can drain). stall/redirect ignored for PC.
//  Bubble = if_instr 0, if_valid 0, if_pc/if_pc4 keep previous values.
//  Latency: PC to if_instr = 1 cycle; redirect to first target instruction in
//   IF/ID = 2 cycles.
// CONFIGURATION
//  FETCH_ALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 in RUN -> pc loads
//   {redirect_pc[31:2],2'b00}, IF/ID <= bubble, state -> HALT (misaligned target
//   is fatal); extra output fetch_misalign (1 bit, reset 0, sticky until rst).
//  Not defined: redirect_pc[1:0] silently masked to 2'b00, no HALT, port absent.
// TESTING
//  Reset, 5 free edges, IM words 0..3 = 0x00008821,0x0000A821,0x24130000,0x24140009
//   -> edge1 BOOT, then if_instr sequence 0x00008821,0x0000A821,..., if_pc 0,4,8.
//  stall=1 for 2 edges at pc=0x8 -> im_addr stays 2, if_instr/if_pc frozen, resume 0xC.
//  redirect=1, redirect_pc=0x28, flush=1 at pc=0x10 -> next if_valid=0, pc=0x28,
//   following edge if_pc=0x28, if_pc4=0x2C, if_instr=mem[10].
//  stall=1 with flush=1 -> IF/ID bubble; stall=1 with redirect=1 -> pc=target.
//  Run to pc=0x100 with IM_DEPTH=64 -> halted=1, if_valid=0, im_addr stays 64.
//  rst pulse mid-run at pc=0x1C -> outputs zero immediately, pc=RESET_PC, BOOT;
//   with FETCH_ALIGN_CHECK_EN, redirect_pc=0x2A -> pc=0x28, fetch_misalign=1, halted=1.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory addressing and IF/ID capture.
// Optional macro FETCH_ALIGN_CHECK_EN makes a misaligned redirect target fatal (HALT + fetch_misalign).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  input  logic [31:0] im_data,
  output logic [31:0] im_addr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
  ,output logic       fetch_misalign
`endif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] if_pc_n, if_pc4_n, if_instr_n;
  logic        if_valid_n;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        out_of_range;
  logic        misalign_req;

  assign pc_plus4     = pc + 32'd4;
  assign target       = {redirect_pc[31:2], 2'b00};
  assign out_of_range = {2'b00, pc[31:2]} >= 32'(IM_DEPTH);
  assign im_addr      = {2'b00, pc[31:2]};
  assign halted       = (state == S_HALT);

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_misalign_n;
  assign misalign_req = redirect && (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign misalign_req        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      if_pc    <= '0;
      if_pc4   <= '0;
      if_instr <= '0;
      if_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      if_pc    <= if_pc_n;
      if_pc4   <= if_pc4_n;
      if_instr <= if_instr_n;
      if_valid <= if_valid_n;
`ifdef FETCH_ALIGN_CHECK_EN
      fetch_misalign <= fetch_misalign_n;
`endif
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    if_pc_n    = if_pc;
    if_pc4_n   = if_pc4;
    if_instr_n = if_instr;
    if_valid_n = if_valid;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_misalign_n = fetch_misalign;
`endif
    case (state)
      S_BOOT: state_n = S_RUN;
      S_RUN: begin
        if (out_of_range) begin
          // Fetch left the image: drop the word, freeze pc, stop.
          if_instr_n = '0;
          if_valid_n = 1'b0;
          state_n    = S_HALT;
        end else begin
          if (redirect)
            pc_n = target;
          else if (!stall)
            pc_n = pc_plus4;

          if (misalign_req) begin
            if_instr_n = '0;
            if_valid_n = 1'b0;
            state_n    = S_HALT;
`ifdef FETCH_ALIGN_CHECK_EN
            fetch_misalign_n = 1'b1;
`endif
          end else if (flush) begin
            if_instr_n = '0;
            if_valid_n = 1'b0;
          end else if (!stall) begin
            if_pc_n    = pc;
            if_pc4_n   = pc_plus4;
            if_instr_n = im_data;
            if_valid_n = 1'b1;
          end

          if (halt_req)
            state_n = S_HALT;
        end
      end
      S_HALT: begin
        // Stall keeps the IF/ID entry so an older instruction can drain.
        if (!stall) begin
          if_instr_n = '0;
          if_valid_n = 1'b0;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed vector bench for if_fetch_stage with a 64-word instruction memory model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0, halt_req = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] im_data, im_addr, if_pc, if_pc4, if_instr;
  logic        if_valid, halted;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:63];

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .IM_DEPTH(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .im_data(im_data),
    .im_addr(im_addr), .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr),
    .if_valid(if_valid), .halted(halted)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  always_comb im_data = (im_addr < 32'd64) ? mem[im_addr[5:0]] : 32'hDEAD_BEEF;

  typedef struct {
    logic        stall, flush, redirect, halt_req;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_pc, e_pc4, e_instr;
    logic        e_valid, e_halted;
  } vec_t;

  vec_t vt [20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] rp, input logic h);
    stall = s; flush = f; redirect = r; redirect_pc = rp; halt_req = h;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    drive(0, 0, 0, 32'h0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    mem[0] = 32'h0000_8821;
    mem[1] = 32'h0000_A821;
    mem[2] = 32'h2413_0000;
    mem[3] = 32'h2414_0009;

    //          stall flush redir halt rpc          addr   if_pc        if_pc4       instr        v  h
    vt[0]  = '{0, 0, 0, 0, 32'h0,  32'd0,  32'h00, 32'h00, 32'h0000_0000, 0, 0}; // BOOT edge
    vt[1]  = '{0, 0, 0, 0, 32'h0,  32'd1,  32'h00, 32'h04, 32'h0000_8821, 1, 0};
    vt[2]  = '{0, 0, 0, 0, 32'h0,  32'd2,  32'h04, 32'h08, 32'h0000_A821, 1, 0};
    vt[3]  = '{1, 0, 0, 0, 32'h0,  32'd2,  32'h04, 32'h08, 32'h0000_A821, 1, 0};
    vt[4]  = '{1, 0, 0, 0, 32'h0,  32'd2,  32'h04, 32'h08, 32'h0000_A821, 1, 0};
    vt[5]  = '{0, 0, 0, 0, 32'h0,  32'd3,  32'h08, 32'h0C, 32'h2413_0000, 1, 0};
    vt[6]  = '{0, 0, 0, 0, 32'h0,  32'd4,  32'h0C, 32'h10, 32'h2414_0009, 1, 0};
    vt[7]  = '{0, 1, 1, 0, 32'h28, 32'd10, 32'h0C, 32'h10, 32'h0000_0000, 0, 0};
    vt[8]  = '{0, 0, 0, 0, 32'h0,  32'd11, 32'h28, 32'h2C, 32'hA000_000A, 1, 0};
    vt[9]  = '{1, 1, 0, 0, 32'h0,  32'd11, 32'h28, 32'h2C, 32'h0000_0000, 0, 0};
    vt[10] = '{1, 0, 1, 0, 32'h40, 32'd16, 32'h28, 32'h2C, 32'h0000_0000, 0, 0};
    vt[11] = '{0, 0, 0, 0, 32'h0,  32'd17, 32'h40, 32'h44, 32'hA000_0010, 1, 0};
    vt[12] = '{0, 0, 1, 0, 32'h48, 32'd18, 32'h44, 32'h48, 32'hA000_0011, 1, 0};
    vt[13] = '{0, 0, 0, 0, 32'h0,  32'd19, 32'h48, 32'h4C, 32'hA000_0012, 1, 0};
    vt[14] = '{0, 1, 1, 0, 32'hF8, 32'd62, 32'h48, 32'h4C, 32'h0000_0000, 0, 0};
    vt[15] = '{0, 0, 0, 0, 32'h0,  32'd63, 32'hF8, 32'hFC, 32'hA000_003E, 1, 0};
    vt[16] = '{0, 0, 0, 0, 32'h0,  32'd64, 32'hFC, 32'h100, 32'hA000_003F, 1, 0};
    vt[17] = '{0, 0, 0, 0, 32'h0,  32'd64, 32'hFC, 32'h100, 32'h0000_0000, 0, 1}; // out of range
    vt[18] = '{1, 0, 1, 0, 32'h0,  32'd64, 32'hFC, 32'h100, 32'h0000_0000, 0, 1};
    vt[19] = '{0, 0, 0, 0, 32'h0,  32'd64, 32'hFC, 32'h100, 32'h0000_0000, 0, 1};

    #2;
    check("reset_addr",   im_addr,  32'd0);
    check("reset_pc",     if_pc,    32'h0);
    check("reset_pc4",    if_pc4,   32'h0);
    check("reset_instr",  if_instr, 32'h0);
    check("reset_valid",  32'(if_valid), 32'd0);
    check("reset_halted", 32'(halted),   32'd0);
    #5;
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].stall, vt[i].flush, vt[i].redirect, vt[i].rpc, vt[i].halt_req);
      step();
      check($sformatf("v%0d_addr", i),   im_addr,  vt[i].e_addr);
      check($sformatf("v%0d_pc", i),     if_pc,    vt[i].e_pc);
      check($sformatf("v%0d_pc4", i),    if_pc4,   vt[i].e_pc4);
      check($sformatf("v%0d_instr", i),  if_instr, vt[i].e_instr);
      check($sformatf("v%0d_valid", i),  32'(if_valid), 32'(vt[i].e_valid));
      check($sformatf("v%0d_halted", i), 32'(halted),   32'(vt[i].e_halted));
    end

    // Reset out of HALT, run to pc=0x1C, then assert rst mid-cycle.
    do_reset();
    check("rst_from_halt_halted", 32'(halted), 32'd0);
    step();
    check("boot_valid", 32'(if_valid), 32'd0);
    for (int i = 0; i < 7; i++) step();
    check("run7_addr", im_addr, 32'd7);
    check("run7_pc",   if_pc,   32'h18);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_instr", if_instr, 32'h0);
    check("async_rst_valid", 32'(if_valid), 32'd0);
    check("async_rst_pc",    if_pc,    32'h0);
    check("async_rst_addr",  im_addr,  32'd0);
    rst = 1'b0;
    step();
    check("reboot_valid", 32'(if_valid), 32'd0);
    check("reboot_addr",  im_addr, 32'd0);
    step();
    check("reboot_instr", if_instr, 32'h0000_8821);

    // halt_req with redirect: HALT wins, pc still loads target, current word captured.
    drive(0, 0, 1, 32'h20, 1);
    step();
    check("haltreq_halted", 32'(halted), 32'd1);
    check("haltreq_addr",   im_addr, 32'd8);
    check("haltreq_instr",  if_instr, 32'h0000_A821);
    drive(0, 0, 1, 32'h30, 0);
    step();
    check("halt_bubble_valid", 32'(if_valid), 32'd0);
    check("halt_pc_held",      im_addr, 32'd8);

    // Misaligned redirect target.
    do_reset();
    step();
    step();
    drive(0, 0, 1, 32'h2A, 0);
    step();
    check("misalign_addr", im_addr, 32'd10);
`ifdef FETCH_ALIGN_CHECK_EN
    check("misalign_halted", 32'(halted), 32'd1);
    check("misalign_flag",   32'(fetch_misalign), 32'd1);
    check("misalign_valid",  32'(if_valid), 32'd0);
    drive(0, 0, 0, 32'h0, 0);
    do_reset();
    check("misalign_flag_rst", 32'(fetch_misalign), 32'd0);
`else
    check("mask_halted", 32'(halted), 32'd0);
    check("mask_instr",  if_instr, 32'h0000_A821);
    drive(0, 0, 0, 32'h0, 0);
    step();
    check("mask_pc",    if_pc,    32'h28);
    check("mask_pc4",   if_pc4,   32'h2C);
    check("mask_instr2", if_instr, 32'hA000_000A);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
